// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream width converter: accepts IN_WIDTH words and replays each
// as R = IN_WIDTH/OUT_WIDTH beats with a last-beat flag, one beat per cycle.
module stream_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  IN_data,
  input  logic                 IN_valid,
  output logic                 OUT_ready,
  output logic [OUT_WIDTH-1:0] OUT_data,
  output logic                 OUT_valid,
  output logic                 OUT_last,
  input  logic                 IN_ready
);

  localparam int R  = IN_WIDTH / OUT_WIDTH;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(R - 1);

  typedef enum logic {EMPTY, SENDING} state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  slice [R];
  logic [OUT_WIDTH-1:0]  beat_data;
  logic                  word_acc;

  // Slice k of the held word is beat k, in the configured emission order.
  for (genvar gi = 0; gi < R; gi++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign slice[gi] = hold_q[(R-1-gi)*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_lsb
      assign slice[gi] = hold_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < R; k++) begin
      if (cnt_q == CW'(k)) beat_data = slice[k];
    end
  end

  assign OUT_data  = beat_data;
  assign OUT_valid = (state_q == SENDING);
  assign OUT_last  = OUT_valid && (cnt_q == LAST_CNT);
  // Ready depends only on registered state and IN_ready, never on IN_valid.
  assign OUT_ready = !OUT_valid || (IN_ready && OUT_last);
  assign word_acc  = IN_valid && OUT_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (word_acc) begin
          hold_d  = IN_data;
          cnt_d   = '0;
          state_d = SENDING;
        end
      end
      SENDING: begin
        if (IN_ready) begin
          if (cnt_q == LAST_CNT) begin
            if (word_acc) begin
              hold_d = IN_data;
              cnt_d  = '0;
            end else begin
              cnt_d   = '0;
              state_d = EMPTY;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed-vector bench for stream_downsizer: per-cycle table for the 32->8 LSB-first
// instance, plus a short hand-written sequence for a 32->16 MSB-first instance.
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  logic        out_ready8, out_valid8, out_last8;
  logic [7:0]  out_data8;
  logic        out_ready16, out_valid16, out_last16;
  logic [15:0] out_data16;

  always #5 clk = ~clk;

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .IN_data(in_data), .IN_valid(in_valid),
    .OUT_ready(out_ready8), .OUT_data(out_data8), .OUT_valid(out_valid8),
    .OUT_last(out_last8), .IN_ready(in_ready)
  );

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) dut16 (
    .clk(clk), .rst(rst), .IN_data(in_data), .IN_valid(in_valid),
    .OUT_ready(out_ready16), .OUT_data(out_data16), .OUT_valid(out_valid16),
    .OUT_last(out_last16), .IN_ready(in_ready)
  );

  typedef struct {
    logic        r;
    logic        iv;
    logic [31:0] d;
    logic        ir;
    logic        e_rdy;
    logic        e_v;
    logic        e_l;
    logic [7:0]  e_d;
    logic        chk_d;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miss    = 0;

  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic ir,
                     input logic e_rdy, input logic e_v, input logic e_l,
                     input logic [7:0] e_d, input logic chk_d);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.ir = ir;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_l = e_l; v.e_d = e_d; v.chk_d = chk_d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //   rst iv  data          ir   rdy  v    l    data   chkd
    // Reset held two cycles with a word offered: nothing accepted.
    add(1, 1, 32'hdeadbeef, 1,  1, 0, 0, 8'h00, 1);
    add(1, 1, 32'hdeadbeef, 1,  1, 0, 0, 8'h00, 1);
    add(0, 0, 32'h0,        1,  1, 0, 0, 8'h00, 1);
    // Single word.
    add(0, 1, 32'hdeadbeef, 1,  1, 0, 0, 8'h00, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'hef, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'hbe, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'had, 1);
    add(0, 0, 32'h0,        1,  1, 1, 1, 8'hde, 1);
    add(0, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0);
    // Back-to-back words, second word waits on the input for three cycles.
    add(0, 1, 32'h03020100, 1,  1, 0, 0, 8'h00, 0);
    add(0, 1, 32'h07060504, 1,  0, 1, 0, 8'h00, 1);
    add(0, 1, 32'h07060504, 1,  0, 1, 0, 8'h01, 1);
    add(0, 1, 32'h07060504, 1,  0, 1, 0, 8'h02, 1);
    add(0, 1, 32'h07060504, 1,  1, 1, 1, 8'h03, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h04, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h05, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h06, 1);
    add(0, 0, 32'h0,        1,  1, 1, 1, 8'h07, 1);
    add(0, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0);
    // Backpressure on beat 1 and on the last beat (with a word offered).
    add(0, 1, 32'hdeadbeef, 1,  1, 0, 0, 8'h00, 0);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'hef, 1);
    add(0, 0, 32'h0,        0,  0, 1, 0, 8'hbe, 1);
    add(0, 0, 32'h0,        0,  0, 1, 0, 8'hbe, 1);
    add(0, 0, 32'h0,        0,  0, 1, 0, 8'hbe, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'hbe, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'had, 1);
    add(0, 1, 32'h11111111, 0,  0, 1, 1, 8'hde, 1);
    add(0, 0, 32'h0,        1,  1, 1, 1, 8'hde, 1);
    add(0, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0);
    // Reset mid-word discards the held word.
    add(0, 1, 32'hdeadbeef, 1,  1, 0, 0, 8'h00, 0);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'hef, 1);
    add(1, 1, 32'h55555555, 1,  0, 1, 0, 8'hbe, 1);
    add(0, 1, 32'h11223344, 1,  1, 0, 0, 8'h00, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h44, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h33, 1);
    add(0, 0, 32'h0,        1,  0, 1, 0, 8'h22, 1);
    add(0, 0, 32'h0,        1,  1, 1, 1, 8'h11, 1);
    add(0, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; in_valid = vecs[i].iv; in_data = vecs[i].d; in_ready = vecs[i].ir;
      #1;
      check("out_ready", i, 32'(out_ready8), 32'(vecs[i].e_rdy));
      check("out_valid", i, 32'(out_valid8), 32'(vecs[i].e_v));
      check("out_last",  i, 32'(out_last8),  32'(vecs[i].e_l));
      if (vecs[i].chk_d) check("out_data", i, 32'(out_data8), 32'(vecs[i].e_d));
      $display("step %0d: rst=%b iv=%b in=%h ir=%b -> rdy=%b v=%b l=%b d=%h",
               i, rst, in_valid, in_data, in_ready, out_ready8, out_valid8, out_last8, out_data8);
      @(negedge clk);
    end

    // 32->16, MSB first: deadbeef -> dead, beef(last).
    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 32'hdeadbeef;
    #1;
    check("msb_rdy0",  100, 32'(out_ready16), 32'd1);
    check("msb_v0",    100, 32'(out_valid16), 32'd0);
    $display("msb step 0: rdy=%b v=%b", out_ready16, out_valid16);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    #1;
    check("msb_v1",    101, 32'(out_valid16), 32'd1);
    check("msb_d1",    101, 32'(out_data16),  32'h0000dead);
    check("msb_l1",    101, 32'(out_last16),  32'd0);
    $display("msb step 1: v=%b l=%b d=%h", out_valid16, out_last16, out_data16);
    @(negedge clk);
    #1;
    check("msb_v2",    102, 32'(out_valid16), 32'd1);
    check("msb_d2",    102, 32'(out_data16),  32'h0000beef);
    check("msb_l2",    102, 32'(out_last16),  32'd1);
    check("msb_rdy2",  102, 32'(out_ready16), 32'd1);
    $display("msb step 2: v=%b l=%b d=%h", out_valid16, out_last16, out_data16);
    @(negedge clk);
    #1;
    check("msb_v3",    103, 32'(out_valid16), 32'd0);
    $display("msb step 3: v=%b", out_valid16);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/stream_downsizer.md
# stream_downsizer

Width-converting stream consumer that sits on the read side of a FIFO. It accepts wide words over a valid/ready handshake and re-emits each word as a sequence of narrower beats over a second valid/ready handshake, with a last-beat flag. Typical use: drain a 32-bit FIFO into a byte-wide datapath. Full throughput is one output beat per cycle, with no bubble between consecutive words.

## Interface
Parameters:
- IN_WIDTH, default 32: input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, default 8: output beat width.
- MSB_FIRST, default 0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.
- Derived: R = IN_WIDTH/OUT_WIDTH beats per word; CW = max(1, $clog2(R)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- IN_data  in  IN_WIDTH  word from upstream (FIFO OUT_data).
- IN_valid  in  1  upstream word valid (FIFO OUT_valid).
- OUT_ready  out  1  block accepts a word this cycle (to FIFO IN_ready).
- OUT_data  out  OUT_WIDTH  current beat.
- OUT_valid  out  1  beat valid.
- OUT_last  out  1  current beat is the final slice of its word.
- IN_ready  in  1  downstream accepts the beat.

## Operation
- Internal state: word register hold[IN_WIDTH], beat counter cnt[CW], flag OUT_valid. OUT_data, OUT_valid and OUT_last are driven from registers.
- States:
  - EMPTY (OUT_valid=0).
  - SENDING (OUT_valid=1, cnt = index of the beat being presented).
- Word accept occurs when IN_valid && OUT_ready.
- OUT_ready = !OUT_valid || (IN_ready && OUT_last). This is combinational from registered state and IN_ready. There is no combinational path from IN_valid.
- Beat transfer occurs when OUT_valid && IN_ready.
- EMPTY:
  - On word accept: hold <= IN_data, cnt <= 0, go to SENDING.
  - Otherwise stay.
- SENDING, beat transfer with cnt < R-1: cnt <= cnt+1.
- SENDING, beat transfer with cnt == R-1 (last beat):
  - If a word is accepted in the same cycle: load the new word, cnt <= 0, stay in SENDING.
  - Otherwise: go to EMPTY.
- SENDING, no transfer: all state holds.
- Beat k is slice hold[k*OUT_WIDTH +: OUT_WIDTH] when MSB_FIRST=0, and slice hold[(R-1-k)*OUT_WIDTH +: OUT_WIDTH] when MSB_FIRST=1.
- OUT_last = OUT_valid && (cnt == R-1).
- R == 1 degenerates to a single-stage register slice; OUT_last equals OUT_valid.
- No arithmetic beyond cnt increment. cnt never exceeds R-1 and never wraps implicitly.

## Timing
- Reset values: OUT_valid=0, OUT_last=0, OUT_data=0, cnt=0, hold=0. Consequently OUT_ready=1 in the first cycle after reset.
- rst has priority over every other event. Asserting rst mid-word discards the remaining beats and the held word. An upstream word presented in a rst cycle is not accepted.
- Latency: a word accepted on edge t has its first beat valid after edge t (visible in cycle t+1).
- Throughput:
  - With IN_ready held high, a word occupies exactly R consecutive cycles.
  - Back-to-back words produce R*N contiguous beats with no idle cycle.
- OUT_ready is high for exactly one cycle per word under full throughput: the cycle in which the last beat transfers.
- Handshake rules:
  - While OUT_valid=1 and IN_ready=0, OUT_data, OUT_last and OUT_valid hold stable.
  - OUT_valid never drops without a completed transfer, except on rst.
  - IN_data is sampled only on word accept; upstream may change it at any other time.
- Simultaneous last-beat transfer and new word accept: the new word's beat 0 is presented the next cycle.
- Upstream empty (IN_valid=0) at the last-beat transfer: OUT_valid=0 the next cycle.

## Test plan
- Reset: hold rst for 2 cycles with IN_valid=1 -> OUT_valid=0, OUT_last=0, OUT_data=0 throughout; no word consumed; OUT_ready=1 after rst deasserts.
- Single word, defaults: IN_data=32'hdeadbeef accepted at cycle t, IN_ready=1 -> OUT_data=ef, be, ad, de in cycles t+1..t+4; OUT_last=1 only at de; OUT_valid=0 at t+5.
- Back-to-back words: 32'h03020100 then 32'h07060504 offered continuously -> OUT_data=00..07 over 8 contiguous cycles; OUT_ready high only in the cycles presenting 03 and 07.
- Backpressure: word 32'hdeadbeef; IN_ready=0 for 3 cycles while beat be is shown -> OUT_data stays be, OUT_valid stays 1, OUT_ready stays 0; sequence resumes with ad.
- Reset mid-word: rst pulsed while beat be is shown -> OUT_valid=0 next cycle; next word 32'h11223344 emits 44 first.
- MSB_FIRST=1, OUT_WIDTH=16: IN_data=32'hdeadbeef -> OUT_data=dead, then beef with OUT_last=1.
